// File: rtl/datatypes_globals_pkg.sv
// Shared payload type and the enums/helpers used by the stream checker.
package datatypes_globals_pkg;

   typedef logic [7:0] rtl_data_t;

   // Backpressure pattern applied on in_ready while running.
   typedef enum logic [1:0] {
      ModeAlways = 2'd0,
      ModeNever  = 2'd1,
      ModeRandom = 2'd2,
      ModeBusy   = 2'd3
   } ready_mode_t;

   typedef enum logic [1:0] {
      SinkIdle = 2'd0,
      SinkRun  = 2'd1,
      SinkDone = 2'd2
   } sink_state_t;

   // Right-shifting Galois LFSR, taps 16,14,13,11.
   localparam logic [15:0] LfsrTaps = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
   endfunction

endpackage

// File: rtl/valid_ready_if.sv
// Valid/ready stream bundle; `in` is the receiver view, `out` the sender view.
interface valid_ready_if
   import datatypes_globals_pkg::*;
#(
   parameter type DATA_T = rtl_data_t
);
   logic  valid;
   logic  ready;
   DATA_T data;

   modport in  (input valid, input data, output ready);
   modport out (output valid, output data, input ready);
endinterface

// File: rtl/ready_pattern_gen.sv
// Backpressure pattern source: LFSR, 2-bit phase counter and the mode mux.
// ready_next is the ready value for the cycle after the current edge.
module ready_pattern_gen
   import datatypes_globals_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        load_seed,
   input  ready_mode_t mode,
   output logic        ready_next
);

   logic [15:0] lfsr_q;
   logic [15:0] cur_lfsr;
   logic [1:0]  phase_q;
   logic [1:0]  cur_phase;

   // A seed load restarts the sequence in the same cycle it is requested.
   always_comb begin
      cur_lfsr  = load_seed ? LFSR_SEED : lfsr_q;
      cur_phase = load_seed ? 2'd0 : phase_q;
      case (mode)
         ModeAlways: ready_next = 1'b1;
         ModeNever:  ready_next = 1'b0;
         ModeRandom: ready_next = cur_lfsr[0];
         ModeBusy:   ready_next = (cur_phase == 2'd3);
         default:    ready_next = 1'b0;
      endcase
   end

   // Step the pattern state once per consumed ready value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lfsr_q  <= LFSR_SEED;
         phase_q <= 2'd0;
      end else if (load_seed || en) begin
         lfsr_q  <= lfsr_step(cur_lfsr);
         phase_q <= cur_phase + 2'd1;
      end
   end

endmodule

// File: rtl/valid_ready_stream_checker.sv
// Receive-end stream checker: programmable backpressure, incrementing-data
// check with resync, protocol (stall stability) check and transfer counting.
module valid_ready_stream_checker
   import datatypes_globals_pkg::*;
#(
   parameter type         DATA_T       = rtl_data_t,
   parameter int unsigned NUM_EXPECTED = 50,
   parameter DATA_T       START_VALUE  = DATA_T'(0),
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  ready_mode_t mode,
   input  logic        start,
   input  logic        in_valid,
   input  DATA_T       in_data,
   output logic        in_ready,
   output logic [15:0] rx_count,
   output logic [15:0] err_count,
   output logic [15:0] first_err_idx,
   output DATA_T       first_err_data,
   output logic        proto_err,
   output logic        done
);

   localparam int unsigned DW = $bits(DATA_T);

   sink_state_t    state_q, state_d;
   ready_mode_t    mode_q, mode_d, mode_sel;
   logic           in_ready_q, in_ready_d;
   logic [15:0]    rx_count_q, rx_count_d;
   logic [15:0]    err_count_q, err_count_d;
   logic [15:0]    first_err_idx_q, first_err_idx_d;
   logic [DW-1:0]  first_err_data_q, first_err_data_d;
   logic           proto_err_q, proto_err_d;
   logic [DW-1:0]  expected_q, expected_d;
   logic           stall_q, stall_d;
   logic [DW-1:0]  stall_data_q, stall_data_d;
   logic [DW-1:0]  rx_data;
   logic           start_ok, xfer, last_xfer, ready_next;

   // Thin adapter: flat ports onto the receiver modport view.
   valid_ready_if #(.DATA_T(DATA_T)) rx_if ();
   assign rx_if.valid = in_valid;
   assign rx_if.data  = in_data;
   assign rx_if.ready = in_ready_q;
   assign in_ready    = rx_if.ready;
   assign rx_data     = rx_if.data;

   assign start_ok  = start && (state_q != SinkRun);
   assign xfer      = (state_q == SinkRun) && rx_if.valid && in_ready_q;
   assign last_xfer = xfer && ((32'(rx_count_q) + 32'd1) == NUM_EXPECTED);
   // Mode is only taken from the port when a run is being started.
   assign mode_sel  = (state_q == SinkRun) ? mode_q : mode;

   ready_pattern_gen #(
      .LFSR_SEED (LFSR_SEED)
   ) u_pattern (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (state_q == SinkRun),
      .load_seed  (start_ok),
      .mode       (mode_sel),
      .ready_next (ready_next)
   );

   // Next-state: FSM, data/protocol checks and saturating counters.
   always_comb begin
      state_d          = state_q;
      mode_d           = mode_q;
      in_ready_d       = 1'b0;
      rx_count_d       = rx_count_q;
      err_count_d      = err_count_q;
      first_err_idx_d  = first_err_idx_q;
      first_err_data_d = first_err_data_q;
      proto_err_d      = proto_err_q;
      expected_d       = expected_q;
      stall_d          = 1'b0;
      stall_data_d     = stall_data_q;
      case (state_q)
         SinkRun: begin
            in_ready_d = ready_next;
            if (stall_q && (!rx_if.valid || (rx_data != stall_data_q))) begin
               proto_err_d = 1'b1;
            end
            stall_d      = rx_if.valid && !in_ready_q;
            stall_data_d = rx_data;
            if (xfer) begin
               if (rx_data != expected_q) begin
                  // err_count saturates, so zero reliably marks the first mismatch.
                  if (err_count_q == 16'd0) begin
                     first_err_idx_d  = rx_count_q;
                     first_err_data_d = rx_data;
                  end
                  if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
               end
               if (rx_count_q != 16'hFFFF) rx_count_d = rx_count_q + 16'd1;
               // Resync on whatever was received.
               expected_d = rx_data + DW'(1);
               if (last_xfer) begin
                  state_d    = SinkDone;
                  in_ready_d = 1'b0;
               end
            end
         end
         default: begin
            if (start) begin
               mode_d           = mode;
               rx_count_d       = 16'd0;
               err_count_d      = 16'd0;
               first_err_idx_d  = 16'd0;
               first_err_data_d = '0;
               proto_err_d      = 1'b0;
               expected_d       = START_VALUE;
               if (NUM_EXPECTED == 0) begin
                  state_d = SinkDone;
               end else begin
                  state_d    = SinkRun;
                  in_ready_d = ready_next;
               end
            end
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= SinkIdle;
         mode_q           <= ModeAlways;
         in_ready_q       <= 1'b0;
         rx_count_q       <= 16'd0;
         err_count_q      <= 16'd0;
         first_err_idx_q  <= 16'd0;
         first_err_data_q <= '0;
         proto_err_q      <= 1'b0;
         expected_q       <= START_VALUE;
         stall_q          <= 1'b0;
         stall_data_q     <= '0;
      end else begin
         state_q          <= state_d;
         mode_q           <= mode_d;
         in_ready_q       <= in_ready_d;
         rx_count_q       <= rx_count_d;
         err_count_q      <= err_count_d;
         first_err_idx_q  <= first_err_idx_d;
         first_err_data_q <= first_err_data_d;
         proto_err_q      <= proto_err_d;
         expected_q       <= expected_d;
         stall_q          <= stall_d;
         stall_data_q     <= stall_data_d;
      end
   end

   assign rx_count       = rx_count_q;
   assign err_count      = err_count_q;
   assign first_err_idx  = first_err_idx_q;
   assign first_err_data = DATA_T'(first_err_data_q);
   assign proto_err      = proto_err_q;
   assign done           = (state_q == SinkDone);

endmodule

// File: tb/tb_valid_ready_stream_checker.sv
// Self-checking bench: cycle model of the checker rules compared every cycle,
// directed scenarios with literal expectations, randomized runs, plus two
// extra instances for saturation and the zero-transfer case.
module tb_valid_ready_stream_checker;
   import datatypes_globals_pkg::*;

   localparam int unsigned NUM  = 50;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          TAB  = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   ready_mode_t mode = ModeAlways;

   logic        in_ready, proto_err, done;
   logic [15:0] rx_count, err_count, first_err_idx;
   logic [7:0]  first_err_data;

   valid_ready_stream_checker #(
      .DATA_T(logic [7:0]), .NUM_EXPECTED(NUM), .START_VALUE(8'd0), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .rx_count(rx_count), .err_count(err_count),
      .first_err_idx(first_err_idx), .first_err_data(first_err_data),
      .proto_err(proto_err), .done(done)
   );

   // NUM_EXPECTED = 0 instance sharing the main stimulus.
   logic        z_in_ready, z_proto_err, z_done;
   logic [15:0] z_rx_count, z_err_count, z_first_err_idx;
   logic [7:0]  z_first_err_data;

   valid_ready_stream_checker #(
      .DATA_T(logic [7:0]), .NUM_EXPECTED(0), .START_VALUE(8'd0), .LFSR_SEED(SEED)
   ) dut_zero (
      .clk(clk), .reset_n(reset_n), .mode(mode), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(z_in_ready), .rx_count(z_rx_count),
      .err_count(z_err_count), .first_err_idx(z_first_err_idx),
      .first_err_data(z_first_err_data), .proto_err(z_proto_err), .done(z_done)
   );

   // Long-run instance for counter saturation and data wrap.
   logic        s_reset_n = 1'b0;
   logic        s_start = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'd0;
   ready_mode_t s_mode = ModeAlways;
   logic        s_in_ready, s_proto_err, s_done;
   logic [15:0] s_rx_count, s_err_count, s_first_err_idx;
   logic [7:0]  s_first_err_data;
   logic        sat_done = 1'b0;

   valid_ready_stream_checker #(
      .DATA_T(logic [7:0]), .NUM_EXPECTED(70000), .START_VALUE(8'd0), .LFSR_SEED(SEED)
   ) dut_sat (
      .clk(clk), .reset_n(s_reset_n), .mode(s_mode), .start(s_start), .in_valid(s_valid),
      .in_data(s_data), .in_ready(s_in_ready), .rx_count(s_rx_count),
      .err_count(s_err_count), .first_err_idx(s_first_err_idx),
      .first_err_data(s_first_err_data), .proto_err(s_proto_err), .done(s_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] lfsr_tab [TAB];
   bit          m_run = 1'b0, m_done = 1'b0, m_ready = 1'b0;
   bit          m_proto = 1'b0, m_stall = 1'b0, m_xfer;
   ready_mode_t m_mode = ModeAlways;
   int          m_k = 0, m_rx = 0, m_err = 0, m_fidx = 0;
   logic [7:0]  m_fdata = 8'd0, m_exp = 8'd0, m_stall_data = 8'd0;
   bit          chk_en = 1'b0;

   function automatic bit pat(input ready_mode_t md, input int k);
      case (md)
         ModeAlways: return 1'b1;
         ModeNever:  return 1'b0;
         ModeRandom: return lfsr_tab[k % TAB][0];
         default:    return (k % 4) == 3;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_run = 0; m_done = 0; m_ready = 0; m_rx = 0; m_err = 0; m_fidx = 0;
         m_fdata = 0; m_proto = 0; m_stall = 0;
      end else if (!m_run) begin
         if (start) begin
            m_mode = mode; m_k = 0; m_rx = 0; m_err = 0; m_fidx = 0; m_fdata = 0;
            m_proto = 0; m_stall = 0; m_exp = 8'd0;
            m_run   = (NUM != 0);
            m_done  = (NUM == 0);
            m_ready = m_run ? pat(mode, 0) : 1'b0;
         end
      end else begin
         if (m_stall && (!in_valid || in_data != m_stall_data)) m_proto = 1;
         m_xfer       = in_valid && m_ready;
         m_stall      = in_valid && !m_ready;
         m_stall_data = in_data;
         if (m_xfer) begin
            if (in_data != m_exp) begin
               if (m_err == 0) begin m_fidx = m_rx; m_fdata = in_data; end
               if (m_err < 65535) m_err++;
            end
            if (m_rx < 65535) m_rx++;
            m_exp = in_data + 8'd1;
            if (m_rx == NUM) begin m_run = 0; m_done = 1; end
         end
         m_k++;
         m_ready = m_run ? pat(m_mode, m_k) : 1'b0;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(m_ready));
         chk("rx_count", 32'(rx_count), 32'(m_rx));
         chk("err_count", 32'(err_count), 32'(m_err));
         chk("first_err_idx", 32'(first_err_idx), 32'(m_fidx));
         chk("first_err_data", 32'(first_err_data), 32'(m_fdata));
         chk("proto_err", 32'(proto_err), 32'(m_proto));
         chk("done", 32'(done), 32'(m_done));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic pulse_start(input ready_mode_t md);
      @(negedge clk);
      mode = md; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Protocol-correct sender; returns cycles spent.
   task automatic send_seq(input logic [7:0] vals[$], input int budget, output int used);
      int  i = 0;
      logic r;
      used = 0;
      while (i < vals.size() && used < budget) begin
         in_valid = 1'b1; in_data = vals[i];
         r = in_ready;
         @(negedge clk);
         used++;
         if (r) i++;
      end
      in_valid = 1'b0;
      chk("send_within_budget", 32'(i), 32'(vals.size()));
   endtask

   task automatic rand_run(input int cycles);
      logic r;
      in_valid = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < cycles; c++) begin
         r = in_ready;
         @(negedge clk);
         start = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 40) == 0) mode = ready_mode_t'($urandom_range(0, 3));
         if (in_valid && r) begin
            in_data  = ($urandom_range(0, 19) == 0) ? 8'($urandom) : in_data + 8'd1;
            in_valid = ($urandom_range(0, 3) != 0);
         end else if (in_valid) begin
            if ($urandom_range(0, 49) == 0) in_valid = 1'b0;
            else if ($urandom_range(0, 49) == 0) in_data = in_data ^ 8'h01;
         end else begin
            in_valid = ($urandom_range(0, 2) != 0);
         end
      end
      start = 1'b0; in_valid = 1'b0;
   endtask

   // ---------------- saturation run ----------------
   initial begin : sat_proc
      int   acc;
      int   cyc;
      logic r;
      acc = 0; cyc = 0;
      repeat (2) @(negedge clk);
      s_reset_n = 1'b1; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0; s_valid = 1'b1;
      while (acc < 65540 && cyc < 70000) begin
         r = s_in_ready;
         @(negedge clk);
         cyc++;
         if (r) begin acc++; s_data = s_data + 8'd1; end
      end
      s_valid = 1'b0;
      chk("sat_accepts", 32'(acc), 32'd65540);
      chk("sat_rx_count", 32'(s_rx_count), 32'h0000FFFF);
      chk("sat_err_count_wrap", 32'(s_err_count), 32'd0);
      chk("sat_not_done", 32'(s_done), 32'd0);
      chk("sat_proto", 32'(s_proto_err), 32'd0);
      sat_done = 1'b1;
   end

   // ---------------- main sequence ----------------
   initial begin : main_proc
      logic [7:0] q[$];
      logic       rec0 [20];
      logic       rec1 [20];
      logic [5:0] pin;
      int         used;
      logic [7:0] d;

      lfsr_tab[0] = SEED;
      for (int i = 1; i < TAB; i++) begin
         lfsr_tab[i] = {1'b0, lfsr_tab[i-1][15:1]} ^ (lfsr_tab[i-1][0] ? 16'hB400 : 16'h0000);
      end
      chk("model_lfsr1", 32'(lfsr_tab[1]), 32'h0000E270);
      chk("model_lfsr5", 32'(lfsr_tab[5]), 32'h00000E27);

      do_reset();
      chk_en = 1'b1;
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_rx", 32'(rx_count), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("zero_idle_done", 32'(z_done), 32'd0);

      // ALWAYS, 0..49 back-to-back.
      q = {};
      for (int i = 0; i < 50; i++) q.push_back(8'(i));
      pulse_start(ModeAlways);
      chk("zero_done_after_start", 32'(z_done), 32'd1);
      chk("zero_no_ready", 32'(z_in_ready), 32'd0);
      send_seq(q, 100, used);
      chk("always_cycles", 32'(used), 32'd50);
      chk("always_done", 32'(done), 32'd1);
      chk("always_rx", 32'(rx_count), 32'd50);
      chk("always_err", 32'(err_count), 32'd0);
      chk("always_ready_low", 32'(in_ready), 32'd0);
      chk("zero_rx", 32'(z_rx_count), 32'd0);

      // Restart from DONE; resync after a jump.
      pulse_start(ModeAlways);
      q = {8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9};
      send_seq(q, 20, used);
      chk("resync_err", 32'(err_count), 32'd1);
      chk("resync_idx", 32'(first_err_idx), 32'd3);
      chk("resync_data", 32'(first_err_data), 32'd7);
      chk("resync_rx", 32'(rx_count), 32'd6);

      // Expected value wraps 255 -> 0.
      do_reset();
      pulse_start(ModeAlways);
      q = {8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
      send_seq(q, 20, used);
      chk("wrap_err", 32'(err_count), 32'd1);
      chk("wrap_idx", 32'(first_err_idx), 32'd0);
      chk("wrap_data", 32'(first_err_data), 32'd250);

      // BUSY: one transfer per 4 cycles.
      do_reset();
      q = {};
      for (int i = 0; i < 50; i++) q.push_back(8'(i));
      pulse_start(ModeBusy);
      send_seq(q, 400, used);
      chk("busy_cycles", 32'(used), 32'd200);
      chk("busy_done", 32'(done), 32'd1);

      // NEVER: valid dropped during stall; later start in RUN is ignored.
      do_reset();
      pulse_start(ModeNever);
      in_valid = 1'b1; in_data = 8'd5;
      repeat (3) @(negedge clk);
      chk("never_no_proto_yet", 32'(proto_err), 32'd0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("never_proto_drop", 32'(proto_err), 32'd1);
      chk("never_rx", 32'(rx_count), 32'd0);
      pulse_start(ModeAlways);
      repeat (3) @(negedge clk);
      chk("start_in_run_ignored", 32'(proto_err), 32'd1);
      chk("never_still_no_ready", 32'(in_ready), 32'd0);

      // NEVER: data changed during stall.
      do_reset();
      pulse_start(ModeNever);
      in_valid = 1'b1; in_data = 8'd9;
      repeat (2) @(negedge clk);
      in_data = 8'd10;
      repeat (2) @(negedge clk);
      chk("never_proto_data", 32'(proto_err), 32'd1);
      in_valid = 1'b0;

      // RANDOM, reset mid-run, then identical replay.
      do_reset();
      pulse_start(ModeRandom);
      d = 8'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = d;
         rec0[i] = in_ready;
         @(negedge clk);
         if (rec0[i]) d = d + 8'd1;
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_ready", 32'(in_ready), 32'd0);
      chk("midrst_rx", 32'(rx_count), 32'd0);
      chk("midrst_err", 32'(err_count), 32'd0);
      chk("midrst_fdata", 32'(first_err_data), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      in_valid = 1'b0;
      pulse_start(ModeRandom);
      for (int i = 0; i < 20; i++) begin
         rec1[i] = in_ready;
         @(negedge clk);
      end
      pin = 6'b100001;
      for (int i = 0; i < 6; i++) chk("random_first_pattern", 32'(rec0[i]), 32'(pin[i]));
      for (int i = 0; i < 20; i++) chk("random_replay", 32'(rec1[i]), 32'(rec0[i]));

      // Randomized runs across modes.
      for (int it = 0; it < 8; it++) begin
         do_reset();
         in_data = 8'($urandom_range(0, 3));
         pulse_start(ready_mode_t'($urandom_range(0, 3)));
         rand_run(160);
      end

      for (int i = 0; i < 80000 && !sat_done; i++) @(negedge clk);
      chk("sat_finished", 32'(sat_done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/valid_ready_stream_checker.md
# valid_ready_stream_checker

Synthesizable receive-end endpoint for the valid/ready stream protocol used by the async FIFO wrappers. It sits on the receiver side of a FIFO `out` port and applies a programmable backpressure pattern on `in_ready`. It checks that accepted data forms an incrementing sequence and that the sender obeys the protocol. It also counts transfers and reports completion, so FIFO bring-up on silicon or FPGA no longer needs the simulation bench.

## Interface
Parameters:
- `DATA_T`, `rtl_data_t`: payload type; `DW = $bits(DATA_T)`.
- `NUM_EXPECTED`, 50: transfers to accept before `done`.
- `START_VALUE`, 0: expected value of the first accepted word.
- `LFSR_SEED`, 16'hACE1: non-zero seed for random backpressure.

Ports:
- `clk`  in  1  single clock; every flop samples on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `mode`  in  2  backpressure mode (`ready_mode_t`): 0 ALWAYS, 1 NEVER, 2 RANDOM, 3 BUSY (ready 1 cycle in 4); sampled only in IDLE.
- `start`  in  1  one-cycle pulse; IDLE -> RUN.
- `in_valid`  in  1  sender valid.
- `in_data`  in  DW  sender payload.
- `in_ready`  out  1  registered ready.
- `rx_count`  out  16  accepted transfers; saturates at 16'hFFFF.
- `err_count`  out  16  data mismatches; saturating.
- `first_err_idx`  out  16  `rx_count` value at the first mismatch.
- `first_err_data`  out  DW  received word at the first mismatch.
- `proto_err`  out  1  sticky; valid dropped or data changed while stalled.
- `done`  out  1  high in DONE.

## Operation
- Handshake: a transfer occurs on a posedge with `in_valid && in_ready`. `in_ready` may change regardless of `in_valid`.
- FSM (`sink_state_t`):
  - IDLE: `in_ready=0`; latch `mode` on `start`; clear counters, errors and the expected value (= `START_VALUE`).
  - RUN: ready follows the pattern; check each transfer.
  - DONE: entered on the cycle when accepted count reaches `NUM_EXPECTED`. `in_ready=0`. Stays in DONE until reset or a new `start`, which goes straight back to RUN with everything cleared.
- Ready pattern (registered, next-state computed from mode):
  - ALWAYS=1 and NEVER=0 in RUN.
  - RANDOM = bit 0 of a 16-bit Galois LFSR (taps 16,14,13,11) that steps every RUN cycle.
  - BUSY = 1 when a 2-bit phase counter == 3; the counter increments every RUN cycle.
- Data check: on each transfer, compare `in_data` against `expected`.
  - Mismatch: increment `err_count`. On the first mismatch only, capture `first_err_idx`/`first_err_data`.
  - Always set `expected = in_data + 1` modulo 2^DW, so the checker resyncs after a dropped or duplicated word.
- Protocol check: a stall is a cycle with `in_valid && !in_ready`. On the next cycle `in_valid` must still be 1 and `in_data` unchanged; otherwise set `proto_err`. Sticky until reset or `start`.
- Counters saturate and never wrap. `expected` wraps.

## Timing
- Reset (`reset_n=0` at a posedge): state IDLE; `in_ready=0`; all counts 0; `first_err_*`=0; `proto_err=0`; `done=0`; LFSR=`LFSR_SEED`; phase=0.
- Reset mid-RUN aborts immediately. Any in-flight word is not accepted.
- `start` at edge N: RUN from N+1. `in_ready` reflects the pattern from N+1 (ALWAYS: `in_ready=1` at N+1).
- `rx_count`, `err_count` and `first_err_*` update one cycle after the accepting edge (registered).
- `done` rises on the cycle after the `NUM_EXPECTED`-th transfer. `in_ready` falls on that same cycle, so no transfer beyond `NUM_EXPECTED` is ever accepted.
- `start` while in RUN is ignored.
- `NUM_EXPECTED=0`: `start` leads to DONE one cycle later with no transfers.

## Structure
- `datatypes_globals_pkg` gains `ready_mode_t` (2-bit enum) and `sink_state_t` (IDLE/RUN/DONE). `rtl_data_t` stays there.
- Sub-module `ready_pattern_gen` holds the LFSR, the phase counter and the mode mux. It has an enable and a load-seed input and outputs `ready_next`.
- The top holds the FSM, the checker and the counters. The top also wraps the flat ports onto a `valid_ready_if.in` modport through a thin adapter, so the block drops onto the async FIFO wrapper `out` port.

## Test plan
- ALWAYS, `NUM_EXPECTED=50`, data 0..49 driven back-to-back -> `in_ready` continuously 1, `done` after 50 transfers, `rx_count=50`, `err_count=0`, `proto_err=0`.
- Sequence 0,1,2,7,8,9 in ALWAYS -> `err_count=1`, `first_err_idx=3`, `first_err_data=7`; words 8 and 9 are not errors (resync).
- BUSY with `in_valid` held high -> exactly one transfer per 4 cycles; 50 transfers take 200 cycles after RUN entry.
- Sender drops `in_valid` (or changes `in_data`) during a stall in NEVER mode -> `proto_err=1`, stays set; `rx_count=0`.
- Expected at `2^DW-1`, then word 0 -> no error (wrap). `rx_count` forced near 16'hFFFF saturates.
- `reset_n` low for one cycle mid-RUN in RANDOM -> all outputs return to reset values the next cycle. A new `start` replays the identical ready sequence from `LFSR_SEED`.
